// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using one double-dabble step per clock.
// An optional two's-complement front end reports the sign and converts the magnitude.
`timescale 1ns / 1ps

module bin2bcd_seq #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3,
  parameter int unsigned SIGNED = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  sign,
  output logic                  overflow,
  output logic                  busy
);

  if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
    $error("bin2bcd_seq: WIDTH must be in 4..32");
  end
  if (DIGITS < 1 || DIGITS > 10) begin : g_bad_digits
    $error("bin2bcd_seq: DIGITS must be in 1..10");
  end
  if (SIGNED > 1) begin : g_bad_signed
    $error("bin2bcd_seq: SIGNED must be 0 or 1");
  end

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);
  localparam logic [BcdW-1:0] AllNines = {DIGITS{4'h9}};

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e          state_q;
  logic [BcdW-1:0] dig_q, dig_adj, dig_nxt;
  logic [WIDTH-1:0] mag_q, mag_nxt;
  logic [CntW-1:0] cnt_q;
  logic            ovf_q, ovf_nxt, neg_q, lost_bit, cap_neg;

  assign cap_neg = (SIGNED != 0) && bin[WIDTH-1];

  // One double-dabble step: add-3 on digits >= 5, then shift {digits, magnitude} left.
  always_comb begin
    dig_adj = dig_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (dig_q[4*k +: 4] >= 4'd5) begin
        dig_adj[4*k +: 4] = dig_q[4*k +: 4] + 4'd3;
      end
    end
    {lost_bit, dig_nxt, mag_nxt} = {dig_adj, mag_q, 1'b0};
    ovf_nxt = ovf_q | lost_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      bcd       <= '0;
      sign      <= 1'b0;
      overflow  <= 1'b0;
      dig_q     <= '0;
      mag_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      neg_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            state_q  <= StShift;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            neg_q    <= cap_neg;
            // Most negative input wraps to 2^(WIDTH-1), which is the correct magnitude.
            mag_q    <= cap_neg ? (~bin + 1'b1) : bin;
            dig_q    <= '0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
          end
        end
        StShift: begin
          dig_q <= dig_nxt;
          mag_q <= mag_nxt;
          ovf_q <= ovf_nxt;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            state_q   <= StDone;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            bcd       <= ovf_nxt ? AllNines : dig_nxt;
            sign      <= neg_q;
            overflow  <= ovf_nxt;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q   <= StIdle;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            bcd       <= '0;
            sign      <= 1'b0;
            overflow  <= 1'b0;
          end
        end
        default: begin
          state_q   <= StIdle;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed vector table, handshake/reset
// sequences, and randomized conversions against a decimal reference model.
`timescale 1ns / 1ps

module tb_bin2bcd_seq;

  localparam int N = 7;
  // Instances: 0 8/3/0, 1 8/3/1, 2 8/2/0, 3..6 16/5/{0,1,0,1}
  localparam int unsigned CW [N] = '{8, 8, 8, 16, 16, 16, 16};
  localparam int unsigned CD [N] = '{3, 3, 2, 5, 5, 5, 5};
  localparam int unsigned CS [N] = '{0, 1, 0, 0, 1, 0, 1};
  localparam int RandPerInst = 2500;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid_s [N];
  logic        out_ready_s [N];
  logic [15:0] bin_s [N];
  logic        in_ready_s [N];
  logic        out_valid_s [N];
  logic        sign_s [N];
  logic        ovf_s [N];
  logic        busy_s [N];
  logic [19:0] bcd_s [N];

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int unsigned W = CW[g];
    localparam int unsigned D = CD[g];
    localparam int unsigned S = CS[g];
    logic [4*D-1:0] bcd_w;
    bin2bcd_seq #(.WIDTH(W), .DIGITS(D), .SIGNED(S)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid_s[g]),
      .in_ready (in_ready_s[g]),
      .bin      (bin_s[g][W-1:0]),
      .out_valid(out_valid_s[g]),
      .out_ready(out_ready_s[g]),
      .bcd      (bcd_w),
      .sign     (sign_s[g]),
      .overflow (ovf_s[g]),
      .busy     (busy_s[g])
    );
    assign bcd_s[g] = 20'(bcd_w);
  end

  typedef struct {
    int          u;
    logic [15:0] b;
    logic [19:0] bcd;
    logic        sign;
    logic        ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Decimal reference: magnitude from plain arithmetic, digits by repeated /10.
  function automatic logic [21:0] model(input int u, input logic [15:0] b);
    longint unsigned mag, lim, p;
    logic [19:0] r;
    logic neg, ovf;
    int unsigned w = CW[u];
    longint unsigned raw = longint'(b) & ((64'd1 << w) - 1);
    neg = (CS[u] == 1) && raw[w-1];
    mag = neg ? ((64'd1 << w) - raw) : raw;
    lim = 1;
    for (int k = 0; k < int'(CD[u]); k++) lim = lim * 10;
    ovf = (mag >= lim);
    r = '0;
    p = 1;
    for (int k = 0; k < int'(CD[u]); k++) begin
      r[4*k +: 4] = ovf ? 4'd9 : 4'((mag / p) % 10);
      p = p * 10;
    end
    return {ovf, neg, r};
  endfunction

  task automatic wait_done(input int u, output int lat);
    lat = 0;
    while (!out_valid_s[u] && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic start(input int u, input logic [15:0] b);
    @(negedge clk);
    bin_s[u] = b;
    in_valid_s[u] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic conv(input int u, input logic [15:0] b, output int lat,
                      output logic [19:0] r_bcd, output logic r_sign, output logic r_ovf);
    start(u, b);
    in_valid_s[u] = 1'b0;
    wait_done(u, lat);
    r_bcd  = bcd_s[u];
    r_sign = sign_s[u];
    r_ovf  = ovf_s[u];
    @(posedge clk);
    #1;
  endtask

  task automatic rand_run(input int u);
    int lat;
    logic [19:0] r_bcd;
    logic r_sign, r_ovf;
    logic [21:0] exp;
    logic [15:0] b;
    for (int i = 0; i < RandPerInst; i++) begin
      b = 16'($urandom);
      if ($urandom_range(7) == 0) begin
        case ($urandom_range(3))
          0: b = 16'h0000;
          1: b = 16'hffff;
          2: b = 16'h8000;
          default: b = 16'h7fff;
        endcase
      end
      exp = model(u, b);
      conv(u, b, lat, r_bcd, r_sign, r_ovf);
      check($sformatf("rand%0d bin=%h lat", u, b), lat, CW[u]);
      check($sformatf("rand%0d bin=%h bcd", u, b), r_bcd, exp[19:0]);
      check($sformatf("rand%0d bin=%h sign", u, b), r_sign, exp[20]);
      check($sformatf("rand%0d bin=%h ovf", u, b), r_ovf, exp[21]);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[13];
    int lat;
    logic [19:0] r_bcd;
    logic r_sign, r_ovf;

    vt[0]  = '{0, 16'd255,   20'h00255, 1'b0, 1'b0};
    vt[1]  = '{0, 16'd0,     20'h00000, 1'b0, 1'b0};
    vt[2]  = '{1, 16'h0080,  20'h00128, 1'b1, 1'b0};
    vt[3]  = '{1, 16'h00f6,  20'h00010, 1'b1, 1'b0};
    vt[4]  = '{2, 16'd100,   20'h00099, 1'b0, 1'b1};
    vt[5]  = '{2, 16'd99,    20'h00099, 1'b0, 1'b0};
    vt[6]  = '{1, 16'h007f,  20'h00127, 1'b0, 1'b0};
    vt[7]  = '{0, 16'd128,   20'h00128, 1'b0, 1'b0};
    vt[8]  = '{3, 16'hffff,  20'h65535, 1'b0, 1'b0};
    vt[9]  = '{4, 16'h8000,  20'h32768, 1'b1, 1'b0};
    vt[10] = '{4, 16'hffff,  20'h00001, 1'b1, 1'b0};
    vt[11] = '{2, 16'd255,   20'h00099, 1'b0, 1'b1};
    vt[12] = '{0, 16'd9,     20'h00009, 1'b0, 1'b0};

    for (int i = 0; i < N; i++) begin
      in_valid_s[i]  = 1'b0;
      out_ready_s[i] = 1'b1;
      bin_s[i]       = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", in_ready_s[0], 1'b1);
    check("reset busy", busy_s[0], 1'b0);
    check("reset out_valid", out_valid_s[0], 1'b0);
    check("reset bcd", bcd_s[0], 20'h0);
    check("reset sign/ovf", {sign_s[1], ovf_s[2]}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      conv(vt[i].u, vt[i].b, lat, r_bcd, r_sign, r_ovf);
      check($sformatf("vec%0d lat", i), lat, CW[vt[i].u]);
      check($sformatf("vec%0d bcd", i), r_bcd, vt[i].bcd);
      check($sformatf("vec%0d sign", i), r_sign, vt[i].sign);
      check($sformatf("vec%0d ovf", i), r_ovf, vt[i].ovf);
    end

    // Backpressure in DONE with in_valid held high throughout.
    out_ready_s[0] = 1'b0;
    start(0, 16'd123);
    check("bp busy after capture", busy_s[0], 1'b1);
    check("bp in_ready in shift", in_ready_s[0], 1'b0);
    bin_s[0] = 16'd200;
    wait_done(0, lat);
    check("bp lat", lat, 8);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp hold%0d bcd", i), bcd_s[0], 20'h00123);
      check($sformatf("bp hold%0d in_ready", i), in_ready_s[0], 1'b0);
      check($sformatf("bp hold%0d out_valid", i), out_valid_s[0], 1'b1);
    end
    out_ready_s[0] = 1'b1;
    bin_s[0] = 16'd77;
    @(posedge clk);
    #1;
    check("bp back idle out_valid", out_valid_s[0], 1'b0);
    check("bp back idle in_ready", in_ready_s[0], 1'b1);
    check("bp back idle bcd", bcd_s[0], 20'h0);
    @(posedge clk);
    #1;
    check("bp recapture busy", busy_s[0], 1'b1);
    in_valid_s[0] = 1'b0;
    wait_done(0, lat);
    check("bp recapture lat", lat, 8);
    check("bp recapture bcd", bcd_s[0], 20'h00077);
    @(posedge clk);
    #1;

    // Reset three clocks into a conversion.
    start(0, 16'd200);
    in_valid_s[0] = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst shift busy", busy_s[0], 1'b0);
    check("rst shift in_ready", in_ready_s[0], 1'b1);
    check("rst shift out_valid", out_valid_s[0], 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    conv(0, 16'd42, lat, r_bcd, r_sign, r_ovf);
    check("rst after lat", lat, 8);
    check("rst after bcd", r_bcd, 20'h00042);
    check("rst after ovf", r_ovf, 1'b0);

    // Reset while holding a result in DONE.
    out_ready_s[1] = 1'b0;
    start(1, 16'h0081);
    in_valid_s[1] = 1'b0;
    wait_done(1, lat);
    check("rst done pre sign", sign_s[1], 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst done out_valid", out_valid_s[1], 1'b0);
    check("rst done bcd", bcd_s[1], 20'h0);
    check("rst done sign", sign_s[1], 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready_s[1] = 1'b1;

    fork
      rand_run(3);
      rand_run(4);
      rand_run(5);
      rand_run(6);
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameter: WIDTH, default 8, binary input width; legal range 4..32; an illegal value SHALL cause an elaboration error.
REQ-002 Parameter: DIGITS, default 3, number of BCD output digits; legal range 1..10; an illegal value SHALL cause an elaboration error.
REQ-003 Parameter: SIGNED, default 0; 0 treats bin as unsigned, 1 treats bin as two's complement.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset, with ports as follows:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  bin is valid.
- in_ready  out  1  block can accept a new input.
- bin  in  WIDTH  binary value to convert.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- bcd  out  4*DIGITS  result digits; digit 0 (ones) in bcd[3:0], digit k in bcd[4k+3:4k].
- sign  out  1  result is negative (SIGNED=1 only; always 0 when SIGNED=0).
- overflow  out  1  magnitude does not fit in DIGITS digits.
- busy  out  1  conversion in progress.

Function
REQ-005 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-006 IDLE: in_ready=1; on in_valid&&in_ready at a clock edge, the block SHALL capture bin and go to SHIFT.
REQ-007 Capture, SIGNED=1 and bin[WIDTH-1]=1: the block SHALL set sign=1 and load the magnitude -bin, computed as a WIDTH-bit unsigned value (so 100...0 yields 2^(WIDTH-1)).
REQ-008 Capture, any other case: the block SHALL set sign=0 and load bin.
REQ-009 Capture SHALL also clear all BCD digits, the overflow flag and the shift counter.
REQ-010 SHIFT: the block SHALL perform exactly one double-dabble step per clock for exactly WIDTH clocks.
- Step: each BCD digit >=5 gets +3.
- Then the combined {digits, magnitude} register shifts left by 1.
REQ-011 Any 1 bit shifted out of the most-significant digit in SHIFT SHALL set overflow, which is sticky until the next capture.
REQ-012 After the WIDTH-th step the block SHALL enter DONE, so that out_valid rises exactly WIDTH clocks after the capture edge.
REQ-013 DONE: out_valid=1; bcd, sign and overflow SHALL be held stable until out_valid&&out_ready at a clock edge, after which the block returns to IDLE.
REQ-014 In DONE with overflow=1, bcd SHALL read as all digits 9 (saturation); sign is still reported.
REQ-015 in_ready SHALL be 1 only in IDLE; in_valid in SHIFT or DONE SHALL be ignored, with no capture and no state change.
REQ-016 busy SHALL be 1 exactly in SHIFT.
REQ-017 out_valid SHALL be 1 exactly in DONE.
REQ-018 bcd, sign and overflow SHALL be register outputs and SHALL be 0 whenever out_valid=0.
REQ-019 Zero input SHALL give bcd=0, sign=0, overflow=0 with the same latency WIDTH.
REQ-020 Latency SHALL be fixed at WIDTH cycles and independent of the input value; there is no early termination.
REQ-021 The minimum interval between captures SHALL be WIDTH+2 cycles: capture, WIDTH shifts, 1 DONE cycle with out_ready=1, then back in IDLE.

Reset
REQ-022 rst_n=0 SHALL immediately and asynchronously force the state to IDLE and clear all internal registers, so that in_ready=1, busy=0, out_valid=0, bcd=0, sign=0, overflow=0.
REQ-023 Reset asserted mid-SHIFT or in DONE SHALL discard the conversion in progress; after rst_n deasserts, the next capture SHALL behave as from power-up.

Verification
REQ-024 The bench SHALL cover the following directed scenarios:
- Defaults (8/3/0), bin=255, out_ready=1 -> out_valid exactly 8 clocks after capture, bcd=0x255, overflow=0.
- Defaults, bin=0 -> bcd=0x000, sign=0, overflow=0, latency 8.
- WIDTH=8, SIGNED=1, bin=8'h80 -> sign=1, bcd=0x128; bin=8'hF6 -> sign=1, bcd=0x010.
- WIDTH=8, DIGITS=2, bin=100 -> overflow=1, bcd=0x99; bin=99 -> overflow=0, bcd=0x99.
- Backpressure: out_ready=0 for 5 clocks in DONE, in_valid=1 throughout -> bcd stable, in_ready=0, no new capture; out_ready=1 -> IDLE next clock, then capture.
- rst_n pulsed low 3 clocks after capture -> outputs cleared immediately; new bin=42 after release -> bcd=0x042 at latency 8.
REQ-025 Randomised check: WIDTH=16, DIGITS=5, SIGNED in {0,1}, 10k random inputs -> bcd, sign and overflow SHALL match a reference decimal model.
